// File: rtl/settings_loader_pkg.sv
// settings_loader_pkg: control-BRAM map, settings structs and group helpers
package settings_loader_pkg;
    localparam int WORD_W       = 16;
    localparam int N_GRP        = 5;
    localparam int SHADOW_DEPTH = 17;
    localparam int IDX_W        = 5;

    localparam int ADDR_CTL_FLAG = 'h000;
    localparam int BASE_MOD      = 'h010;
    localparam int LEN_MOD       = 12;
    localparam int BASE_STM      = 'h020;
    localparam int LEN_STM       = 17;
    localparam int BASE_SILENCER = 'h040;
    localparam int LEN_SILENCER  = 5;
    localparam int BASE_SYNC     = 'h050;
    localparam int LEN_SYNC      = 6;
    localparam int BASE_DEBUG    = 'h060;
    localparam int LEN_DEBUG     = 16;

    localparam int MOD_REQ_RD_SEGMENT   = 0;
    localparam int MOD_CYCLE            = 1;
    localparam int MOD_FREQ_DIV         = 3;
    localparam int MOD_REP              = 5;
    localparam int MOD_TRANSITION_MODE  = 7;
    localparam int MOD_TRANSITION_VALUE = 8;

    localparam int STM_REQ_RD_SEGMENT   = 0;
    localparam int STM_CYCLE            = 1;
    localparam int STM_FREQ_DIV         = 3;
    localparam int STM_REP              = 5;
    localparam int STM_SOUND_SPEED      = 7;
    localparam int STM_MODE             = 9;
    localparam int STM_NUM_FOCI         = 11;
    localparam int STM_TRANSITION_MODE  = 12;
    localparam int STM_TRANSITION_VALUE = 13;

    localparam int SIL_FLAG                       = 0;
    localparam int SIL_UPDATE_RATE_INTENSITY      = 1;
    localparam int SIL_UPDATE_RATE_PHASE          = 2;
    localparam int SIL_COMPLETION_STEPS_INTENSITY = 3;
    localparam int SIL_COMPLETION_STEPS_PHASE     = 4;

    localparam int SYNC_UFREQ_MULT     = 0;
    localparam int SYNC_BASE_CNT       = 1;
    localparam int SYNC_ECAT_SYNC_TIME = 2;

    localparam int DBG_VALUE = 0;

    localparam int MOD_CYCLE_W       = 15;
    localparam int STM_CYCLE_W       = 13;
    localparam int UFREQ_MULT_W      = 9;
    localparam int BASE_CNT_W        = 13;
    localparam int TRANSITION_MODE_W = 8;
    localparam int NUM_FOCI_W        = 8;
    localparam int SIL_FLAG_W        = 8;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [SHADOW_DEPTH-1:0][WORD_W-1:0] shadow_t;
    typedef enum logic [2:0] {GRP_MOD, GRP_STM, GRP_SILENCER, GRP_SYNC, GRP_DEBUG} grp_e;
    typedef enum logic [1:0] {POLL, LOAD, COMMIT} state_e;

    typedef struct packed {
        logic                                UPDATE;
        logic                                REQ_RD_SEGMENT;
        logic [1:0][MOD_CYCLE_W-1:0]         CYCLE;
        logic [1:0][WORD_W-1:0]              FREQ_DIV;
        logic [1:0][WORD_W-1:0]              REP;
        logic [TRANSITION_MODE_W-1:0]        TRANSITION_MODE;
        logic [63:0]                         TRANSITION_VALUE;
    } mod_settings_t;

    typedef struct packed {
        logic                                UPDATE;
        logic                                REQ_RD_SEGMENT;
        logic [1:0][STM_CYCLE_W-1:0]         CYCLE;
        logic [1:0][WORD_W-1:0]              FREQ_DIV;
        logic [1:0][WORD_W-1:0]              REP;
        logic [1:0][WORD_W-1:0]              SOUND_SPEED;
        logic [1:0]                          MODE;
        logic [NUM_FOCI_W-1:0]               NUM_FOCI;
        logic [TRANSITION_MODE_W-1:0]        TRANSITION_MODE;
        logic [63:0]                         TRANSITION_VALUE;
    } stm_settings_t;

    typedef struct packed {
        logic                  UPDATE;
        logic [SIL_FLAG_W-1:0] FLAG;
        logic [WORD_W-1:0]     UPDATE_RATE_INTENSITY;
        logic [WORD_W-1:0]     UPDATE_RATE_PHASE;
        logic [WORD_W-1:0]     COMPLETION_STEPS_INTENSITY;
        logic [WORD_W-1:0]     COMPLETION_STEPS_PHASE;
    } silencer_settings_t;

    typedef struct packed {
        logic                    UPDATE;
        logic [UFREQ_MULT_W-1:0] UFREQ_MULT;
        logic [BASE_CNT_W-1:0]   BASE_CNT;
        logic [63:0]             ECAT_SYNC_TIME;
    } sync_settings_t;

    typedef struct packed {
        logic             UPDATE;
        logic [3:0][63:0] VALUE;
    } debug_settings_t;

    function automatic int grp_base(input grp_e g);
        return g == GRP_MOD ? BASE_MOD : g == GRP_STM ? BASE_STM :
               g == GRP_SILENCER ? BASE_SILENCER : g == GRP_SYNC ? BASE_SYNC : BASE_DEBUG;
    endfunction

    function automatic int grp_len(input grp_e g);
        return g == GRP_MOD ? LEN_MOD : g == GRP_STM ? LEN_STM :
               g == GRP_SILENCER ? LEN_SILENCER : g == GRP_SYNC ? LEN_SYNC : LEN_DEBUG;
    endfunction

    function automatic grp_e lowest_pending(input logic [N_GRP-1:0] p);
        lowest_pending = GRP_MOD;
        for (int k = N_GRP - 1; k >= 0; k--)
            if (p[k]) lowest_pending = grp_e'(3'(k));
    endfunction

    function automatic bit map_fits(input int aw);
        return BASE_MOD + LEN_MOD <= 2**aw && BASE_STM + LEN_STM <= 2**aw &&
               BASE_SILENCER + LEN_SILENCER <= 2**aw && BASE_SYNC + LEN_SYNC <= 2**aw &&
               BASE_DEBUG + LEN_DEBUG <= 2**aw;
    endfunction
endpackage

// File: rtl/settings_loader_if.sv
// settings_loader_if: control-BRAM read port between loader and BRAM
interface settings_loader_if
    import settings_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] BRAM_ADDR;
    logic [WORD_W-1:0]     BRAM_DOUT;
    modport master (output BRAM_ADDR, input BRAM_DOUT);
    modport slave (input BRAM_ADDR, output BRAM_DOUT);
endinterface

// File: rtl/settings_loader_bram_rd_pipe.sv
// bram_rd_pipe: tags each BRAM read with its word index until its data returns
module bram_rd_pipe
    import settings_loader_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic in_valid,
    input  idx_t in_idx,
    output logic out_valid,
    output idx_t out_idx
);
    logic [LATENCY-1:0]            v;
    logic [LATENCY:0]              v_in;
    logic [LATENCY-1:0][IDX_W-1:0] ix;
    logic [LATENCY:0][IDX_W-1:0]   ix_in;

    assign v_in      = {v, in_valid};
    assign ix_in     = {ix, in_idx};
    assign out_valid = v[LATENCY-1];
    assign out_idx   = ix[LATENCY-1];

    // shift valid/index one stage per cycle; reset drops in-flight reads
    always_ff @(posedge CLK) begin
        v  <= RST ? '0 : v_in[LATENCY-1:0];
        ix <= ix_in[LATENCY-1:0];
    end
endmodule

// File: rtl/settings_loader.sv
// settings_loader: polls control-BRAM toggle flags and loads one settings group per request
module settings_loader
    import settings_loader_pkg::*;
#(
    parameter int BRAM_LATENCY = 2,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic               CLK,
    input  logic               RST,
    settings_loader_if.master  bram,
    output mod_settings_t      MOD_SETTINGS,
    output stm_settings_t      STM_SETTINGS,
    output silencer_settings_t SILENCER_SETTINGS,
    output sync_settings_t     SYNC_SETTINGS,
    output debug_settings_t    DEBUG_SETTINGS,
    output logic               BUSY
);
    state_e             state;
    grp_e               grp;
    logic [N_GRP-1:0]   seen, pend;
    idx_t               cnt, pidx;
    logic               pv, issue, cap_last;
    shadow_t            sh, sh_n;
    mod_settings_t      mod_n;
    stm_settings_t      stm_n;
    silencer_settings_t sil_n;
    sync_settings_t     sync_n;
    debug_settings_t    dbg_n;

    assign pend     = bram.BRAM_DOUT[N_GRP-1:0] ^ seen;
    assign issue    = (state == LOAD) && (cnt < idx_t'(grp_len(grp)));
    assign cap_last = pv && (pidx == idx_t'(grp_len(grp) - 1));

    bram_rd_pipe #(.LATENCY(BRAM_LATENCY)) u_pipe (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (issue),
        .in_idx    (cnt),
        .out_valid (pv),
        .out_idx   (pidx)
    );

    // address map and latency must stay inside the BRAM
    always_ff @(posedge CLK) assert (map_fits(ADDR_WIDTH) && BRAM_LATENCY >= 1 && BRAM_LATENCY <= 4);

    // shadow with the returning word merged, unpacked into every group's struct
    always_comb begin
        sh_n = sh;
        if (pv) sh_n[pidx] = bram.BRAM_DOUT;
        mod_n  = '0;
        stm_n  = '0;
        sil_n  = '0;
        sync_n = '0;
        dbg_n  = '0;
        mod_n.UPDATE           = 1'b1;
        mod_n.REQ_RD_SEGMENT   = sh_n[MOD_REQ_RD_SEGMENT][0];
        mod_n.TRANSITION_MODE  = sh_n[MOD_TRANSITION_MODE][TRANSITION_MODE_W-1:0];
        mod_n.TRANSITION_VALUE = sh_n[MOD_TRANSITION_VALUE +: 4];
        stm_n.UPDATE           = 1'b1;
        stm_n.REQ_RD_SEGMENT   = sh_n[STM_REQ_RD_SEGMENT][0];
        stm_n.NUM_FOCI         = sh_n[STM_NUM_FOCI][NUM_FOCI_W-1:0];
        stm_n.TRANSITION_MODE  = sh_n[STM_TRANSITION_MODE][TRANSITION_MODE_W-1:0];
        stm_n.TRANSITION_VALUE = sh_n[STM_TRANSITION_VALUE +: 4];
        for (int k = 0; k < 2; k++) begin
            mod_n.CYCLE[k]       = sh_n[MOD_CYCLE + k][MOD_CYCLE_W-1:0];
            mod_n.FREQ_DIV[k]    = sh_n[MOD_FREQ_DIV + k];
            mod_n.REP[k]         = sh_n[MOD_REP + k];
            stm_n.CYCLE[k]       = sh_n[STM_CYCLE + k][STM_CYCLE_W-1:0];
            stm_n.FREQ_DIV[k]    = sh_n[STM_FREQ_DIV + k];
            stm_n.REP[k]         = sh_n[STM_REP + k];
            stm_n.SOUND_SPEED[k] = sh_n[STM_SOUND_SPEED + k];
            stm_n.MODE[k]        = sh_n[STM_MODE + k][0];
        end
        sil_n.UPDATE                     = 1'b1;
        sil_n.FLAG                       = sh_n[SIL_FLAG][SIL_FLAG_W-1:0];
        sil_n.UPDATE_RATE_INTENSITY      = sh_n[SIL_UPDATE_RATE_INTENSITY];
        sil_n.UPDATE_RATE_PHASE          = sh_n[SIL_UPDATE_RATE_PHASE];
        sil_n.COMPLETION_STEPS_INTENSITY = sh_n[SIL_COMPLETION_STEPS_INTENSITY];
        sil_n.COMPLETION_STEPS_PHASE     = sh_n[SIL_COMPLETION_STEPS_PHASE];
        sync_n.UPDATE         = 1'b1;
        sync_n.UFREQ_MULT     = sh_n[SYNC_UFREQ_MULT][UFREQ_MULT_W-1:0];
        sync_n.BASE_CNT       = sh_n[SYNC_BASE_CNT][BASE_CNT_W-1:0];
        sync_n.ECAT_SYNC_TIME = sh_n[SYNC_ECAT_SYNC_TIME +: 4];
        dbg_n.UPDATE = 1'b1;
        for (int k = 0; k < 4; k++)
            dbg_n.VALUE[k] = sh_n[DBG_VALUE + 4 * k +: 4];
    end

    // poll/load/commit sequencer; outputs are committed on the last capture so they are valid during COMMIT
    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= POLL;
            grp               <= GRP_MOD;
            seen              <= '0;
            cnt               <= '0;
            BUSY              <= 1'b0;
            bram.BRAM_ADDR    <= '0;
            sh                <= '0;
            MOD_SETTINGS      <= '0;
            STM_SETTINGS      <= '0;
            SILENCER_SETTINGS <= '0;
            SYNC_SETTINGS     <= '0;
            DEBUG_SETTINGS    <= '0;
        end else begin
            sh                       <= sh_n;
            MOD_SETTINGS.UPDATE      <= 1'b0;
            STM_SETTINGS.UPDATE      <= 1'b0;
            SILENCER_SETTINGS.UPDATE <= 1'b0;
            SYNC_SETTINGS.UPDATE     <= 1'b0;
            DEBUG_SETTINGS.UPDATE    <= 1'b0;
            case (state)
                POLL: begin
                    if (cnt != idx_t'(BRAM_LATENCY)) begin
                        cnt <= cnt + idx_t'(1);
                    end else if (|pend) begin
                        grp            <= lowest_pending(pend);
                        bram.BRAM_ADDR <= ADDR_WIDTH'(grp_base(lowest_pending(pend)));
                        cnt            <= '0;
                        BUSY           <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    if (issue) begin
                        cnt            <= cnt + idx_t'(1);
                        bram.BRAM_ADDR <= bram.BRAM_ADDR + ADDR_WIDTH'(1);
                    end
                    if (cap_last) begin
                        state <= COMMIT;
                        if (grp == GRP_MOD) MOD_SETTINGS <= mod_n;
                        if (grp == GRP_STM) STM_SETTINGS <= stm_n;
                        if (grp == GRP_SILENCER) SILENCER_SETTINGS <= sil_n;
                        if (grp == GRP_SYNC) SYNC_SETTINGS <= sync_n;
                        if (grp == GRP_DEBUG) DEBUG_SETTINGS <= dbg_n;
                    end
                end
                COMMIT: begin
                    seen[grp]      <= ~seen[grp];
                    BUSY           <= 1'b0;
                    cnt            <= '0;
                    bram.BRAM_ADDR <= ADDR_WIDTH'(ADDR_CTL_FLAG);
                    state          <= POLL;
                end
                default: state <= POLL;
            endcase
        end
    end
endmodule
